ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. It is the send side of the keyboard link.
//  It sends one command byte to the keyboard (0xED set-LEDs, 0xFF reset, 0xF4 enable).
//  It shares the ps2c/ps2d lines with the scan-code receiver. Lines are open-drain: this block only drives low or releases.
//  tx_busy high tells the receiver to ignore clock edges during a host frame.

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 58 +++++
 rtl/ps2_host_tx.sv | 166 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: command codes, default
// timing, FSM states and the frame builder.
package ps2_host_tx_pkg;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_RTS_CYCLES     = 250;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FILTER_LEN     = 8;

  // Falls needed to move from the start bit to the stop bit.
  localparam int FRAME_FALLS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } state_e;

  // Start bit sits in bit 0 so the data line simply follows ~frame[0].
  function automatic logic [10:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on clock and data, a
// consecutive-sample debounce on the clock and a falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_filt_o,
  output logic ps2c_fall_o,
  output logic ps2d_sync_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    c_sync_q, d_sync_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (c_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = c_sync_q[1];
        fall_d = filt_q & ~c_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_i};
      d_sync_q <= {d_sync_q[0], ps2d_i};
      filt_q   <= filt_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ps2c_filt_o = filt_q;
  assign ps2c_fall_o = fall_q;
  assign ps2d_sync_o = d_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send,
// shifts out one command byte on device clock falls and checks the ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] RTS_MARK = INH_W'(INHIBIT_CYCLES - RTS_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_FALLS - 1);

  logic ps2c_filt, ps2c_fall, ps2d_sync;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_i       (clk),
    .rst_ni      (reset),
    .ps2c_i      (ps2c_in),
    .ps2d_i      (ps2d_in),
    .ps2c_filt_o (ps2c_filt),
    .ps2c_fall_o (ps2c_fall),
    .ps2d_sync_o (ps2d_sync)
  );

  state_e            state_q, state_d;
  logic [10:0]       shreg_q, shreg_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ps2c_oe_q, ps2c_oe_d;
  logic              ps2d_oe_q, ps2d_oe_d;
  logic              timed, timeout_hit;

  assign timed       = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout_hit = timed && (to_cnt_q >= TO_LAST);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = (timed && to_cnt_q != TO_MAX) ? to_cnt_q + 1'b1 : to_cnt_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;

    unique case (state_q)
      ST_IDLE: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        if (tx_start) begin
          state_d   = ST_INHIBIT;
          shreg_d   = build_frame(tx_data);
          bitcnt_d  = '0;
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          ps2c_oe_d = 1'b1;
        end
      end
      ST_INHIBIT: begin
        ps2c_oe_d = 1'b1;
        // Outputs are registered, so compare one count early.
        ps2d_oe_d = (inh_cnt_q >= RTS_MARK);
        if (inh_cnt_q == INH_LAST) begin
          state_d   = ST_SEND;
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = ~shreg_q[0];
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (timeout_hit) begin
          state_d   = ST_ERR;
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b0;
        end else if (ps2c_fall) begin
          shreg_d   = {1'b1, shreg_q[10:1]};
          ps2d_oe_d = ~shreg_q[1];
          bitcnt_d  = (bitcnt_q == 4'hF) ? bitcnt_q : bitcnt_q + 4'd1;
          if (bitcnt_q == BIT_LAST) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        ps2d_oe_d = 1'b0;
        if (timeout_hit) begin
          state_d   = ST_ERR;
          ps2c_oe_d = 1'b0;
        end else if (ps2c_fall) begin
          state_d = ps2d_sync ? ST_ERR : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (timeout_hit) begin
          state_d = ST_ERR;
        end else if (ps2c_filt && ps2d_sync) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
      end
      ST_ERR: begin
        state_d   = ST_IDLE;
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '1;
      bitcnt_q  <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
    end
  end

  assign ps2c_oe = ps2c_oe_q;
  assign ps2d_oe = ps2d_oe_q;
  assign tx_busy = (state_q != ST_IDLE);
  assign tx_done = (state_q == ST_DONE);
  assign tx_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 100;
  localparam int RTS = 20;
  localparam int TO  = 3000;
  localparam int FL  = 4;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int err_total = 0;
  int both_total = 0;

  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_total <= done_total + 1;
    if (tx_err) err_total <= err_total + 1;
    if (tx_done && tx_err) both_total <= both_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One host frame against the device model; inject_k/reset_k select the bit
  // period in which a mid-frame disturbance or an abort is applied.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic exp_par,
                           input logic ack_low, input logic exp_done, input logic exp_err,
                           input int inject_k, input int reset_k);
    int d0, e0, n, rts;
    logic [10:0] bits;
    d0 = done_total;
    e0 = err_total;
    bits = '1;
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = 8'h00;
    check({tag, " busy_latency"}, tx_busy, 1);
    n = 0;
    rts = 0;
    while (ps2c_oe && n < INH + 50) begin
      n++;
      if (ps2d_oe) rts++;
      @(negedge clk);
    end
    check({tag, " inhibit_len"}, n, INH);
    check({tag, " rts_lead"}, rts, RTS);
    bits[0] = ps2d_in;
    for (int k = 1; k <= 10; k++) begin
      if (k == inject_k) begin
        wait_cycles(10);
        dev_clk = 1'b0;
        wait_cycles(3);
        dev_clk = 1'b1;
        tx_start = 1'b1;
        tx_data = PS2_CMD_ENABLE;
        wait_cycles(1);
        tx_start = 1'b0;
        tx_data = 8'h00;
        wait_cycles(H - 14);
      end else begin
        wait_cycles(H);
      end
      dev_clk = 1'b0;
      if (k == reset_k) begin
        wait_cycles(H / 2);
        check({tag, " pre_reset_busy"}, tx_busy, 1);
        check({tag, " pre_reset_dat_oe"}, ps2d_oe, 1);
        #2 reset = 1'b0;
        #1;
        check({tag, " async_rst_clk_oe"}, ps2c_oe, 0);
        check({tag, " async_rst_dat_oe"}, ps2d_oe, 0);
        check({tag, " async_rst_busy"}, tx_busy, 0);
        @(negedge clk);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(5);
        return;
      end
      wait_cycles(H);
      dev_clk = 1'b1;
      bits[k] = ps2d_in;
    end
    wait_cycles(H);
    if (ack_low) dev_dat = 1'b0;
    wait_cycles(2);
    dev_clk = 1'b0;
    wait_cycles(H);
    dev_clk = 1'b1;
    wait_cycles(2);
    dev_dat = 1'b1;
    n = 0;
    while (tx_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_release"}, tx_busy, 0);
    wait_cycles(30);
    check({tag, " no_requeue"}, tx_busy, 0);
    check({tag, " start_bit"}, bits[0], 0);
    check({tag, " data_bits"}, bits[8:1], d);
    check({tag, " parity_bit"}, bits[9], exp_par);
    check({tag, " stop_bit"}, bits[10], 1);
    check({tag, " done_count"}, done_total - d0, exp_done);
    check({tag, " err_count"}, err_total - e0, exp_err);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ack_low;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int e0;
    vecs[0] = '{PS2_CMD_SETLED, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00,          1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{PS2_CMD_RESET,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h01,          1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{PS2_CMD_SETLED, 1'b1, 1'b0, 1'b0, 1'b1};

    wait_cycles(3);
    check("reset clk_oe", ps2c_oe, 0);
    check("reset dat_oe", ps2d_oe, 0);
    check("reset busy", tx_busy, 0);
    check("reset done", tx_done, 0);
    check("reset err", tx_err, 0);
    reset = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i].data, vecs[i].par,
                vecs[i].ack_low, vecs[i].exp_done, vecs[i].exp_err, 0, 0);
    end

    // Busy-time start request plus a short clock glitch must not disturb the frame.
    run_frame("glitch_ed", PS2_CMD_SETLED, 1'b1, 1'b1, 1'b1, 1'b0, 4, 0);

    // Silent device: error exactly TIMEOUT cycles after clock release.
    e0 = err_total;
    @(negedge clk);
    tx_data = PS2_CMD_SETLED;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dev_clk = 1'b1;
    n = 0;
    while (ps2c_oe && n < INH + 50) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!tx_err && n < TO + 50) begin
      n++;
      @(negedge clk);
    end
    check("timeout len", n, TO);
    check("timeout clk_oe", ps2c_oe, 0);
    check("timeout dat_oe", ps2d_oe, 0);
    check("timeout busy_in_err", tx_busy, 1);
    @(negedge clk);
    check("timeout busy_after", tx_busy, 0);
    check("timeout err_count", err_total - e0, 1);

    // Abort after the fourth fall, then a clean frame.
    run_frame("reset_abort", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4);
    run_frame("post_reset_ed", PS2_CMD_SETLED, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);

    check("done_err_exclusive", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, limit 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
